// File: rtl/bosconian_pkg.sv
// Shared definitions for the Bosconian core's hiscore RAM access path.
//   hs_state_t  : responder FSM states
//   hs_region_t : decoded RAM region of a CPU-space address
//   HS_*        : default CPU-space placement of the two hiscore-visible RAMs
//   region_hit  : compares the bits of an address above a region's size
package bosconian_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GRANT,
    RD_WAIT
  } hs_state_t;

  typedef enum logic [1:0] {
    NONE,
    A,
    B
  } hs_region_t;

  // Region A: shared work RAM, region B: video RAM.
  localparam logic [15:0] HS_BASE_A      = 16'h7800;
  localparam int          HS_SIZE_A_LOG2 = 11;
  localparam logic [15:0] HS_BASE_B      = 16'h8000;
  localparam int          HS_SIZE_B_LOG2 = 12;

  // Width of the RAM word address; the largest region is 4 KB.
  localparam int HS_OFFSET_W = 12;

  // An address is inside a region when all bits above the region size match
  // the region base.
  function automatic logic region_hit(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input int          size_log2);
    return (addr >> size_log2) == (base >> size_log2);
  endfunction

endpackage

// File: rtl/hs_addr_decode.sv
// Combinational CPU-space address decoder for the hiscore-visible RAMs.
// Shared with the core's RAM muxes so both sides agree on the memory map.
//   addr    in  16  CPU-space address
//   region  out     NONE / A / B; A wins if both match
//   offset  out 12  zero-extended offset inside the region, 0 when NONE
//   overlap out  1  both regions match (parameter misconfiguration)
module hs_addr_decode
  import bosconian_pkg::*;
#(
  parameter logic [15:0] BASE_A      = HS_BASE_A,
  parameter int          SIZE_A_LOG2 = HS_SIZE_A_LOG2,
  parameter logic [15:0] BASE_B      = HS_BASE_B,
  parameter int          SIZE_B_LOG2 = HS_SIZE_B_LOG2
) (
  input  logic [15:0]            addr,
  output hs_region_t             region,
  output logic [HS_OFFSET_W-1:0] offset,
  output logic                   overlap
);

  localparam logic [15:0] MASK_A = 16'((32'd1 << SIZE_A_LOG2) - 32'd1);
  localparam logic [15:0] MASK_B = 16'((32'd1 << SIZE_B_LOG2) - 32'd1);

  logic hit_a;
  logic hit_b;

  always_comb begin
    // NOTE: every output gets a default before the decisions below, so no
    // path through the block leaves a value unassigned and no latch is built.
    region  = NONE;
    offset  = '0;
    hit_a   = region_hit(addr, BASE_A, SIZE_A_LOG2);
    hit_b   = region_hit(addr, BASE_B, SIZE_B_LOG2);
    overlap = hit_a && hit_b;
    if (hit_a) begin
      region = A;
      offset = addr[HS_OFFSET_W-1:0] & MASK_A[HS_OFFSET_W-1:0];
    end else if (hit_b) begin
      region = B;
      offset = addr[HS_OFFSET_W-1:0] & MASK_B[HS_OFFSET_W-1:0];
    end
  end

endmodule

// File: rtl/hs_ram_port.sv
// Responder side of the hiscore RAM access interface inside the Bosconian
// core. It stalls the CPUs, then serves single-byte reads and writes from the
// hiscore engine against work RAM (region A) and video RAM (region B).
//   clock_18, reset_n          core clock, synchronous active-low reset
//   hs_pause_req               engine wants the bus (level)
//   hs_address/data_in         request address and write data
//   hs_write_enable, hs_read   one-cycle requests, accepted only in GRANT
//   hs_data_out, hs_done       read data / completion strobe
//   hs_granted, hs_unmapped    bus owned / sticky out-of-map flag
//   cpu_hold, cpu_idle         stall request to the bus masters and its ack
//   ram_*                      strobe to the shared-RAM muxes, 0 when unused
// Write latency is 1 clock. Read latency is RAM_LAT+1 clocks: ram_dout_* is
// sampled RAM_LAT edges after the edge that launches the read strobe.
module hs_ram_port
  import bosconian_pkg::*;
#(
  parameter logic [15:0] BASE_A      = HS_BASE_A,
  parameter int          SIZE_A_LOG2 = HS_SIZE_A_LOG2,
  parameter logic [15:0] BASE_B      = HS_BASE_B,
  parameter int          SIZE_B_LOG2 = HS_SIZE_B_LOG2,
  parameter int          RAM_LAT     = 1
) (
  input  logic        clock_18,
  input  logic        reset_n,
  input  logic        hs_pause_req,
  input  logic [15:0] hs_address,
  input  logic [7:0]  hs_data_in,
  input  logic        hs_write_enable,
  input  logic        hs_read,
  output logic [7:0]  hs_data_out,
  output logic        hs_done,
  output logic        hs_granted,
  output logic        hs_unmapped,
  output logic        cpu_hold,
  input  logic        cpu_idle,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        ram_sel_a,
  output logic        ram_sel_b,
  input  logic [7:0]  ram_dout_a,
  input  logic [7:0]  ram_dout_b
);

  // Remaining RD_WAIT cycles after the first one.
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

  hs_state_t              state_q,       state_d;
  logic [1:0]             lat_cnt_q,     lat_cnt_d;
  logic [HS_OFFSET_W-1:0] ram_addr_q,    ram_addr_d;
  logic [7:0]             ram_din_q,     ram_din_d;
  logic                   ram_we_q,      ram_we_d;
  logic                   ram_sel_a_q,   ram_sel_a_d;
  logic                   ram_sel_b_q,   ram_sel_b_d;
  logic [7:0]             hs_data_out_q, hs_data_out_d;
  logic                   hs_done_q,     hs_done_d;
  logic                   hs_unmapped_q, hs_unmapped_d;

  hs_region_t             dec_region;
  logic [HS_OFFSET_W-1:0] dec_offset;
  logic                   dec_overlap;
  logic                   dec_mapped;

  hs_addr_decode #(
    .BASE_A      (BASE_A),
    .SIZE_A_LOG2 (SIZE_A_LOG2),
    .BASE_B      (BASE_B),
    .SIZE_B_LOG2 (SIZE_B_LOG2)
  ) u_decode (
    .addr    (hs_address),
    .region  (dec_region),
    .offset  (dec_offset),
    .overlap (dec_overlap)
  );

  assign dec_mapped = (dec_region != NONE);

  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    // RAM controls fall back to 0 every cycle so the core muxes return to
    // the CPUs unless an access is launched or a read is still waiting.
    ram_addr_d    = '0;
    ram_din_d     = '0;
    ram_we_d      = 1'b0;
    ram_sel_a_d   = 1'b0;
    ram_sel_b_d   = 1'b0;
    hs_data_out_d = hs_data_out_q;
    hs_done_d     = 1'b0;
    hs_unmapped_d = hs_unmapped_q;

    unique case (state_q)
      IDLE: begin
        if (hs_pause_req) state_d = HOLD;
      end

      HOLD: begin
        if (!hs_pause_req)  state_d = IDLE;
        else if (cpu_idle)  state_d = GRANT;
      end

      GRANT: begin
        if (!hs_pause_req) begin
          state_d = IDLE;
        end else if (hs_write_enable || hs_read) begin
          // Unmapped accesses raise no strobe but still complete normally.
          ram_sel_a_d = (dec_region == A);
          ram_sel_b_d = (dec_region == B);
          ram_addr_d  = dec_offset;
          if (!dec_mapped) hs_unmapped_d = 1'b1;
          // A write wins over a simultaneous read; the read is dropped.
          if (hs_write_enable) begin
            ram_we_d  = dec_mapped;
            ram_din_d = dec_mapped ? hs_data_in : 8'h00;
            hs_done_d = 1'b1;
          end else begin
            state_d   = RD_WAIT;
            lat_cnt_d = LAT_LOAD;
          end
        end
      end

      RD_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          // Both selects low means an unmapped read, which returns 0.
          hs_data_out_d = ram_sel_a_q ? ram_dout_a :
                          ram_sel_b_q ? ram_dout_b : 8'h00;
          hs_done_d     = 1'b1;
          // Back through GRANT so a dropped pause releases the CPUs one
          // cycle after the completion strobe.
          state_d       = GRANT;
        end else begin
          ram_sel_a_d = ram_sel_a_q;
          ram_sel_b_d = ram_sel_b_q;
          ram_addr_d  = ram_addr_q;
          lat_cnt_d   = lat_cnt_q - 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_18) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q       <= IDLE;
      lat_cnt_q     <= '0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
      ram_sel_a_q   <= 1'b0;
      ram_sel_b_q   <= 1'b0;
      hs_data_out_q <= '0;
      hs_done_q     <= 1'b0;
      hs_unmapped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
      ram_sel_a_q   <= ram_sel_a_d;
      ram_sel_b_q   <= ram_sel_b_d;
      hs_data_out_q <= hs_data_out_d;
      hs_done_q     <= hs_done_d;
      hs_unmapped_q <= hs_unmapped_d;
    end
  end

  assign cpu_hold    = (state_q != IDLE);
  assign hs_granted  = (state_q == GRANT);
  assign hs_data_out = hs_data_out_q;
  assign hs_done     = hs_done_q;
  assign hs_unmapped = hs_unmapped_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign ram_sel_a   = ram_sel_a_q;
  assign ram_sel_b   = ram_sel_b_q;

  // Overlapping regions mean the parameters are wrong; region A is used.
  a_no_overlap: assert property (@(posedge clock_18) disable iff (!reset_n)
                                 !dec_overlap);

endmodule

// File: tb/tb_hs_ram_port.sv
// Directed bench for hs_ram_port. Two instances share all inputs: one with
// RAM_LAT=1 (l1_*) and one with RAM_LAT=3 (l3_*), each with its own RAM model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_hs_ram_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        we;
  logic        rd;
  logic        cpu_idle;

  logic [7:0]  l1_dout, l3_dout;
  logic        l1_done, l1_gnt, l1_unm, l1_hold;
  logic        l3_done, l3_gnt, l3_unm, l3_hold;
  logic [11:0] l1_addr, l3_addr;
  logic [7:0]  l1_din, l3_din;
  logic        l1_we, l1_sa, l1_sb, l3_we, l3_sa, l3_sb;
  logic [7:0]  l1_ra, l1_rb, l3_ra, l3_rb;

  // Packed views: st = {done, granted, unmapped, cpu_hold},
  // ram = {sel_a, sel_b, we, addr, din}.
  logic [3:0]  l1_st, l3_st;
  logic [22:0] l1_ram, l3_ram;
  assign l1_st  = {l1_done, l1_gnt, l1_unm, l1_hold};
  assign l3_st  = {l3_done, l3_gnt, l3_unm, l3_hold};
  assign l1_ram = {l1_sa, l1_sb, l1_we, l1_addr, l1_din};
  assign l3_ram = {l3_sa, l3_sb, l3_we, l3_addr, l3_din};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hs_ram_port #(.RAM_LAT(1)) u_dut_l1 (
    .clock_18(clk), .reset_n(reset_n), .hs_pause_req(pause),
    .hs_address(addr), .hs_data_in(din), .hs_write_enable(we), .hs_read(rd),
    .hs_data_out(l1_dout), .hs_done(l1_done), .hs_granted(l1_gnt),
    .hs_unmapped(l1_unm), .cpu_hold(l1_hold), .cpu_idle(cpu_idle),
    .ram_addr(l1_addr), .ram_din(l1_din), .ram_we(l1_we),
    .ram_sel_a(l1_sa), .ram_sel_b(l1_sb),
    .ram_dout_a(l1_ra), .ram_dout_b(l1_rb)
  );

  hs_ram_port #(.RAM_LAT(3)) u_dut_l3 (
    .clock_18(clk), .reset_n(reset_n), .hs_pause_req(pause),
    .hs_address(addr), .hs_data_in(din), .hs_write_enable(we), .hs_read(rd),
    .hs_data_out(l3_dout), .hs_done(l3_done), .hs_granted(l3_gnt),
    .hs_unmapped(l3_unm), .cpu_hold(l3_hold), .cpu_idle(cpu_idle),
    .ram_addr(l3_addr), .ram_din(l3_din), .ram_we(l3_we),
    .ram_sel_a(l3_sa), .ram_sel_b(l3_sb),
    .ram_dout_a(l3_ra), .ram_dout_b(l3_rb)
  );

  // RAM models. Data is ready RAM_LAT-1 cycles after the address appears,
  // matching the RAM_LAT-edge sampling point of the port.
  logic [7:0] mem_a1 [0:2047];
  logic [7:0] mem_b1 [0:4095];
  logic [7:0] mem_a3 [0:2047];
  logic [7:0] mem_b3 [0:4095];
  logic [7:0] s1_a3, s2_a3, s1_b3, s2_b3;

  always @(posedge clk) begin
    if (l1_we && l1_sa) mem_a1[l1_addr[10:0]] <= l1_din;
    if (l1_we && l1_sb) mem_b1[l1_addr]       <= l1_din;
  end
  assign l1_ra = mem_a1[l1_addr[10:0]];
  assign l1_rb = mem_b1[l1_addr];

  always @(posedge clk) begin
    if (l3_we && l3_sa) mem_a3[l3_addr[10:0]] <= l3_din;
    if (l3_we && l3_sb) mem_b3[l3_addr]       <= l3_din;
    s1_a3 <= mem_a3[l3_addr[10:0]];
    s2_a3 <= s1_a3;
    s1_b3 <= mem_b3[l3_addr];
    s2_b3 <= s1_b3;
  end
  assign l3_ra = s2_a3;
  assign l3_rb = s2_b3;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(2);
    total++; if ({l1_st, l1_ram, l1_dout} !== 35'd0) begin bad++; $display("FAIL reset_l1 got=%h want=0", {l1_st, l1_ram, l1_dout}); end
    total++; if ({l3_st, l3_ram, l3_dout} !== 35'd0) begin bad++; $display("FAIL reset_l3 got=%h want=0", {l3_st, l3_ram, l3_dout}); end
    reset_n = 1'b1;
    tick();
    total++; if (l1_st !== 4'b0000) begin bad++; $display("FAIL idle_l1 got=%b want=0000", l1_st); end
  endtask

  task automatic test_hold_handshake;
    pause = 1'b1;
    tick();
    total++; if (l1_st !== 4'b0001) begin bad++; $display("FAIL hold_rise_l1 got=%b want=0001", l1_st); end
    total++; if (l3_st !== 4'b0001) begin bad++; $display("FAIL hold_rise_l3 got=%b want=0001", l3_st); end
    tick(4);
    total++; if (l1_st !== 4'b0001) begin bad++; $display("FAIL hold_wait_l1 got=%b want=0001", l1_st); end
    cpu_idle = 1'b1;
    tick();
    total++; if (l1_st !== 4'b0101) begin bad++; $display("FAIL grant_l1 got=%b want=0101", l1_st); end
    total++; if (l3_st !== 4'b0101) begin bad++; $display("FAIL grant_l3 got=%b want=0101", l3_st); end
  endtask

  task automatic test_region_a;
    addr = 16'h7810; din = 8'h5A; we = 1'b1;
    tick(); we = 1'b0;
    total++; if (l1_ram !== {3'b101, 12'h010, 8'h5A}) begin bad++; $display("FAIL wr_a_ram_l1 got=%h want=%h", l1_ram, {3'b101, 12'h010, 8'h5A}); end
    total++; if (l1_st !== 4'b1101) begin bad++; $display("FAIL wr_a_done_l1 got=%b want=1101", l1_st); end
    total++; if (l3_st !== 4'b1101) begin bad++; $display("FAIL wr_a_done_l3 got=%b want=1101", l3_st); end
    tick();
    total++; if ({l1_st, l1_ram} !== {4'b0101, 23'd0}) begin bad++; $display("FAIL wr_a_idle_l1 got=%h want=%h", {l1_st, l1_ram}, {4'b0101, 23'd0}); end
    rd = 1'b1;
    tick(); rd = 1'b0;
    total++; if (l1_ram !== {3'b100, 12'h010, 8'h00}) begin bad++; $display("FAIL rd_a_ram_l1 got=%h want=%h", l1_ram, {3'b100, 12'h010, 8'h00}); end
    total++; if (l1_st !== 4'b0001) begin bad++; $display("FAIL rd_a_wait_l1 got=%b want=0001", l1_st); end
    tick();
    total++; if ({l1_st, l1_dout} !== {4'b1101, 8'h5A}) begin bad++; $display("FAIL rd_a_l1 got=%h want=%h", {l1_st, l1_dout}, {4'b1101, 8'h5A}); end
    total++; if (l3_ram !== {3'b100, 12'h010, 8'h00}) begin bad++; $display("FAIL rd_a_held_l3 got=%h want=%h", l3_ram, {3'b100, 12'h010, 8'h00}); end
    total++; if (l3_st !== 4'b0001) begin bad++; $display("FAIL rd_a_early_l3 got=%b want=0001", l3_st); end
    tick();
    total++; if ({l1_st, l1_dout} !== {4'b0101, 8'h5A}) begin bad++; $display("FAIL rd_a_keep_l1 got=%h want=%h", {l1_st, l1_dout}, {4'b0101, 8'h5A}); end
    tick();
    total++; if ({l3_st, l3_dout, l3_ram} !== {4'b1101, 8'h5A, 23'd0}) begin bad++; $display("FAIL rd_a_l3 got=%h want=%h", {l3_st, l3_dout, l3_ram}, {4'b1101, 8'h5A, 23'd0}); end
  endtask

  task automatic test_back_to_back;
    we = 1'b1;
    addr = 16'h7820; din = 8'h11; tick();
    total++; if ({l1_st, l1_ram} !== {4'b1101, 3'b101, 12'h020, 8'h11}) begin bad++; $display("FAIL b2b_0 got=%h want=%h", {l1_st, l1_ram}, {4'b1101, 3'b101, 12'h020, 8'h11}); end
    addr = 16'h7821; din = 8'h22; tick();
    total++; if ({l1_st, l1_ram} !== {4'b1101, 3'b101, 12'h021, 8'h22}) begin bad++; $display("FAIL b2b_1 got=%h want=%h", {l1_st, l1_ram}, {4'b1101, 3'b101, 12'h021, 8'h22}); end
    addr = 16'h8005; din = 8'h33; tick();
    total++; if ({l3_st, l3_ram} !== {4'b1101, 3'b011, 12'h005, 8'h33}) begin bad++; $display("FAIL b2b_2 got=%h want=%h", {l3_st, l3_ram}, {4'b1101, 3'b011, 12'h005, 8'h33}); end
    we = 1'b0; tick();
    total++; if ({l1_st, l1_ram} !== {4'b0101, 23'd0}) begin bad++; $display("FAIL b2b_end got=%h want=%h", {l1_st, l1_ram}, {4'b0101, 23'd0}); end
    addr = 16'h7821; rd = 1'b1; tick(); rd = 1'b0;
    tick();
    total++; if ({l1_done, l1_dout} !== {1'b1, 8'h22}) begin bad++; $display("FAIL b2b_rd_l1 got=%h want=%h", {l1_done, l1_dout}, {1'b1, 8'h22}); end
    tick(2);
    total++; if ({l3_done, l3_dout} !== {1'b1, 8'h22}) begin bad++; $display("FAIL b2b_rd_l3 got=%h want=%h", {l3_done, l3_dout}, {1'b1, 8'h22}); end
  endtask

  task automatic test_region_b;
    addr = 16'h8FFF; din = 8'hC3; we = 1'b1; tick(); we = 1'b0;
    total++; if (l1_ram !== {3'b011, 12'hFFF, 8'hC3}) begin bad++; $display("FAIL wr_b_top got=%h want=%h", l1_ram, {3'b011, 12'hFFF, 8'hC3}); end
    tick();
    rd = 1'b1; tick(); rd = 1'b0;
    total++; if (l3_ram !== {3'b010, 12'hFFF, 8'h00}) begin bad++; $display("FAIL rd_b_top_ram got=%h want=%h", l3_ram, {3'b010, 12'hFFF, 8'h00}); end
    tick();
    total++; if ({l1_st, l1_dout} !== {4'b1101, 8'hC3}) begin bad++; $display("FAIL rd_b_top_l1 got=%h want=%h", {l1_st, l1_dout}, {4'b1101, 8'hC3}); end
    tick(2);
    total++; if ({l3_st, l3_dout} !== {4'b1101, 8'hC3}) begin bad++; $display("FAIL rd_b_top_l3 got=%h want=%h", {l3_st, l3_dout}, {4'b1101, 8'hC3}); end
    addr = 16'h9000; rd = 1'b1; tick(); rd = 1'b0;
    total++; if ({l1_ram, l3_ram} !== 46'd0) begin bad++; $display("FAIL unmapped_strobe got=%h want=0", {l1_ram, l3_ram}); end
    total++; if (l1_st !== 4'b0011) begin bad++; $display("FAIL unmapped_flag got=%b want=0011", l1_st); end
    tick();
    total++; if ({l1_st, l1_dout} !== {4'b1111, 8'h00}) begin bad++; $display("FAIL unmapped_rd_l1 got=%h want=%h", {l1_st, l1_dout}, {4'b1111, 8'h00}); end
    tick(2);
    total++; if ({l3_st, l3_dout} !== {4'b1111, 8'h00}) begin bad++; $display("FAIL unmapped_rd_l3 got=%h want=%h", {l3_st, l3_dout}, {4'b1111, 8'h00}); end
  endtask

  task automatic test_simultaneous;
    int n_done = 0;
    addr = 16'h7800; din = 8'h33; we = 1'b1; rd = 1'b1;
    tick(); we = 1'b0; rd = 1'b0;
    total++; if ({l1_st, l1_ram} !== {4'b1111, 3'b101, 12'h000, 8'h33}) begin bad++; $display("FAIL simul_l1 got=%h want=%h", {l1_st, l1_ram}, {4'b1111, 3'b101, 12'h000, 8'h33}); end
    total++; if (l3_st !== 4'b1111) begin bad++; $display("FAIL simul_l3 got=%b want=1111", l3_st); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_done += int'(l1_done) + int'(l3_done);
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL simul_extra_done got=%0d want=0", n_done); end
    rd = 1'b1; tick(); rd = 1'b0;
    tick();
    total++; if ({l1_done, l1_dout} !== {1'b1, 8'h33}) begin bad++; $display("FAIL simul_ram_l1 got=%h want=%h", {l1_done, l1_dout}, {1'b1, 8'h33}); end
    tick(2);
    total++; if ({l3_done, l3_dout} !== {1'b1, 8'h33}) begin bad++; $display("FAIL simul_ram_l3 got=%h want=%h", {l3_done, l3_dout}, {1'b1, 8'h33}); end
  endtask

  task automatic test_ignored_in_rd_wait;
    addr = 16'h7810; rd = 1'b1; tick(); rd = 1'b0;
    addr = 16'h7830; din = 8'h77; we = 1'b1; tick(); we = 1'b0;
    total++; if ({l1_st, l1_dout, l1_ram} !== {4'b1111, 8'h5A, 23'd0}) begin bad++; $display("FAIL rdwait_l1 got=%h want=%h", {l1_st, l1_dout, l1_ram}, {4'b1111, 8'h5A, 23'd0}); end
    total++; if ({l3_st, l3_ram} !== {4'b0011, 3'b100, 12'h010, 8'h00}) begin bad++; $display("FAIL rdwait_l3 got=%h want=%h", {l3_st, l3_ram}, {4'b0011, 3'b100, 12'h010, 8'h00}); end
    tick(2);
    total++; if ({l3_st, l3_dout} !== {4'b1111, 8'h5A}) begin bad++; $display("FAIL rdwait_done_l3 got=%h want=%h", {l3_st, l3_dout}, {4'b1111, 8'h5A}); end
  endtask

  task automatic test_release_during_read;
    addr = 16'h7810; rd = 1'b1; tick(); rd = 1'b0;
    pause = 1'b0;
    tick();
    total++; if (l1_st !== 4'b1111) begin bad++; $display("FAIL rel_done_l1 got=%b want=1111", l1_st); end
    tick();
    total++; if (l1_st !== 4'b0010) begin bad++; $display("FAIL rel_drop_l1 got=%b want=0010", l1_st); end
    total++; if (l3_st !== 4'b0011) begin bad++; $display("FAIL rel_wait_l3 got=%b want=0011", l3_st); end
    tick();
    total++; if ({l3_st, l3_dout} !== {4'b1111, 8'h5A}) begin bad++; $display("FAIL rel_done_l3 got=%h want=%h", {l3_st, l3_dout}, {4'b1111, 8'h5A}); end
    tick();
    total++; if (l3_st !== 4'b0010) begin bad++; $display("FAIL rel_drop_l3 got=%b want=0010", l3_st); end
  endtask

  task automatic test_reset_mid_read;
    logic [34:0] seen = '0;
    pause = 1'b1;
    tick(2);
    total++; if (l3_st !== 4'b0111) begin bad++; $display("FAIL regrant_l3 got=%b want=0111", l3_st); end
    addr = 16'h7810; rd = 1'b1; tick(); rd = 1'b0;
    reset_n = 1'b0; pause = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if ({l1_st, l1_ram, l1_dout} !== 35'd0) begin bad++; $display("FAIL midrd_rst_l1 got=%h want=0", {l1_st, l1_ram, l1_dout}); end
    total++; if ({l3_st, l3_ram, l3_dout} !== 35'd0) begin bad++; $display("FAIL midrd_rst_l3 got=%h want=0", {l3_st, l3_ram, l3_dout}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= {l1_st, l1_ram, l1_dout} | {l3_st, l3_ram, l3_dout};
    end
    total++; if (seen !== 35'd0) begin bad++; $display("FAIL midrd_after got=%h want=0", seen); end
  endtask

  initial begin
    reset_n  = 1'b0;
    pause    = 1'b0;
    addr     = 16'h0000;
    din      = 8'h00;
    we       = 1'b0;
    rd       = 1'b0;
    cpu_idle = 1'b0;
    test_reset();
    test_hold_handshake();
    test_region_a();
    test_back_to_back();
    test_region_b();
    test_simultaneous();
    test_ignored_in_rd_wait();
    test_release_during_read();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_ram_port.md
Name: hs_ram_port

Overview:
- Responder side of the hiscore RAM access interface. It serves the hiscore engine's address, data, write-enable and pause requests against the Bosconian core's on-chip RAMs.
- Sits inside the bosconian core and owns the hiscore side of the shared-RAM muxes. It holds the CPUs off the bus before touching RAM.
- It returns read data with a fixed, documented latency and raises a done strobe per access.

Parameters:
- BASE_A, 16'h7800, CPU address of region A (shared work RAM).
- SIZE_A_LOG2, 11, log2 of region A size in bytes (2 KB).
- BASE_B, 16'h8000, CPU address of region B (video RAM).
- SIZE_B_LOG2, 12, log2 of region B size in bytes (4 KB).
- RAM_LAT, 1, registered read latency of the RAMs in clocks (1..3).

Ports:
- clock_18  in  1  core clock.
- reset_n  in  1  synchronous, active-low reset.
- hs_pause_req  in  1  hiscore engine requests bus ownership (level).
- hs_address  in  16  CPU-space address.
- hs_data_in  in  8  write data from the hiscore engine.
- hs_write_enable  in  1  one-cycle write request.
- hs_read  in  1  one-cycle read request.
- hs_data_out  out  8  read data, valid when hs_done=1.
- hs_done  out  1  one-cycle completion strobe per accepted request.
- hs_granted  out  1  bus owned; requests are accepted only while this is high.
- hs_unmapped  out  1  sticky flag: an access fell outside A and B; cleared by reset.
- cpu_hold  out  1  stall request to all three CPUs and the DMA/Namco I/O.
- cpu_idle  in  1  all bus masters are stalled at a cycle boundary.
- ram_addr  out  12  RAM word address (region offset).
- ram_din  out  8  write data to the RAMs.
- ram_we  out  1  write strobe.
- ram_sel_a  out  1  selects region A.
- ram_sel_b  out  1  selects region B.
- ram_dout_a  in  8  region A read data.
- ram_dout_b  in  8  region B read data.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State becomes IDLE.
  - Every output goes to 0, including hs_unmapped and hs_data_out.
  - An in-flight access is abandoned; no hs_done is issued.
- States: IDLE, HOLD, GRANT, RD_WAIT.
  - IDLE: cpu_hold=0. hs_pause_req=1 moves to HOLD on the next cycle.
  - HOLD: cpu_hold=1. Moves to GRANT on the first cycle where cpu_idle=1. hs_pause_req dropping here returns to IDLE with cpu_hold deasserted the next cycle.
  - GRANT: cpu_hold=1 and hs_granted=1. Request handling is described below.
  - RD_WAIT: counts RAM_LAT cycles, then captures data and returns to GRANT.
- Write in GRANT:
  - Address decode and the RAM strobe (ram_sel_*, ram_addr, ram_din, ram_we=1) happen in the same cycle as the request, registered to the next cycle.
  - hs_done pulses on that next cycle. Write latency is 1 clock.
- Read in GRANT:
  - The RAM is strobed as for a write, with ram_we=0, then the block enters RD_WAIT.
  - After RAM_LAT cycles it captures ram_dout_a or ram_dout_b according to the latched select.
  - hs_data_out and hs_done update together. Total read latency is RAM_LAT+1 clocks from the request.
  - hs_data_out holds its value until the next read completes.
- Hold release:
  - hs_pause_req=0 in GRANT with no access pending returns to IDLE; cpu_hold falls the next cycle.
  - hs_pause_req=0 in RD_WAIT first completes the read, with hs_done issued, then returns to IDLE.
- Address decode:
  - Region A when hs_address[15:SIZE_A_LOG2] == BASE_A[15:SIZE_A_LOG2]. Region B is decoded the same way with its own parameters.
  - The offset is zero-extended to 12 bits.
  - If both regions match, A wins. This is a parameter misconfiguration; the block asserts in simulation.
- Unmapped access:
  - No RAM strobe is issued and hs_unmapped is set.
  - A read returns 8'h00 with normal latency. A write completes with hs_done at latency 1.
- Illegal requests:
  - hs_read and hs_write_enable both high in the same cycle: the write takes priority and the read is dropped.
  - Requests outside GRANT, including during RD_WAIT, are ignored: no hs_done and no RAM strobe.
- Back-to-back writes are accepted on consecutive cycles, one per clock. A read blocks new requests until its hs_done.
- The RAM control outputs (ram_addr, ram_din, ram_we, ram_sel_a, ram_sel_b) are all 0 whenever no access is in progress, so the core RAM muxes default to the CPUs.

Decomposition:
- Shared package bosconian_pkg holds:
  - the state enum hs_state_t;
  - region constants HS_BASE_A, HS_BASE_B and their size logs;
  - typedef hs_region_t {NONE, A, B}.
- One natural sub-module: hs_addr_decode. It is combinational and maps address to region and offset; it is reused by the RAM muxes in the core.

Test Plan:
- Hold handshake: raise hs_pause_req, keep cpu_idle=0 for 5 cycles, then set it to 1 -> cpu_hold rises 1 cycle after the request; hs_granted rises exactly 1 cycle after cpu_idle.
- Region A write then read, RAM_LAT=1:
  - write 8'h5A to 16'h7810 -> ram_sel_a=1, ram_addr=12'h010, ram_we=1, hs_done 1 clock later;
  - read the same address -> hs_data_out=8'h5A with hs_done 2 clocks after the request.
- Region B boundary: read 16'h8FFF -> ram_sel_b=1, ram_addr=12'hFFF; read 16'h9000 -> hs_data_out=8'h00, hs_unmapped=1, no RAM strobe.
- Release during read (RAM_LAT=3): drop hs_pause_req one cycle after the read request -> hs_done arrives at latency 4, then cpu_hold falls the next cycle.
- Simultaneous hs_read and hs_write_enable to 16'h7800 with data 8'h33 -> exactly one hs_done, after 1 clock; RAM holds 8'h33.
- Reset mid-read: pulse reset_n low during RD_WAIT -> no hs_done; all outputs 0; state IDLE; hs_unmapped cleared.
